// File: rtl/serial_byte_receiver.sv
// serial_byte_receiver: ser_clk-oversampled byte deserializer with frame counting and a byte FIFO; define RX_MSB_FIRST_EN for MSB-first assembly
module serial_byte_receiver #(
  parameter int FRAME_BYTES = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ser_clk,
  input  logic             ser_data,
  input  logic             ser_active,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_valid,
  output logic [CNT_W-1:0] byte_count,
  output logic             frame_done,
  output logic             overflow,
  output logic             frame_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] sclk_q, sdat_q, sact_q;
  logic sclk_prev_q;
  logic rise, act, bit_in;
  logic [2:0] bit_cnt_q, bit_cnt_d, pos;
  logic [7:0] shift_q, shift_d, shift_nx;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic ovf_q, ovf_d, ferr_q, ferr_d;
  logic push, pop, full, wr_en;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  assign rise = sclk_q[1] & ~sclk_prev_q;
  assign act = sact_q[1];
  assign bit_in = sdat_q[1];
`ifdef RX_MSB_FIRST_EN
  assign pos = 3'd7 - bit_cnt_q;
`else
  assign pos = bit_cnt_q;
`endif
  assign full = cnt_q == (AW+1)'(FIFO_DEPTH);
  assign out_valid = cnt_q != '0;
  assign pop = out_valid & out_ready;
  assign wr_en = push & (~full | pop);
  assign out_data = mem_q[rd_q];
  assign byte_count = byte_cnt_q;
  assign frame_done = state_q == DONE;
  assign overflow = ovf_q;
  assign frame_err = ferr_q;
  always_comb begin
    state_d = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d = shift_q;
    byte_cnt_d = byte_cnt_q;
    ovf_d = ovf_q;
    ferr_d = ferr_q;
    push = 1'b0;
    shift_nx = shift_q;
    shift_nx[pos] = bit_in;
    case (state_q)
      IDLE: if (act) begin
        state_d = SHIFT;
        bit_cnt_d = '0;
        byte_cnt_d = '0;
        ovf_d = 1'b0;
        ferr_d = 1'b0;
      end
      SHIFT: if (!act) begin
        state_d = IDLE;
        ferr_d = 1'b1;
        bit_cnt_d = '0;
      end else if (rise) begin
        shift_d = shift_nx;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          push = 1'b1;
          byte_cnt_d = byte_cnt_q + 1'b1;
          ovf_d = ovf_q | (full & ~pop);
          if (byte_cnt_d == CNT_W'(FRAME_BYTES)) state_d = DONE;
        end
      end
      DONE: if (!act) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      {sclk_q, sdat_q, sact_q, sclk_prev_q} <= '0;
      bit_cnt_q <= '0;
      shift_q <= '0;
      byte_cnt_q <= '0;
      ovf_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sclk_q <= {sclk_q[0], ser_clk};
      sdat_q <= {sdat_q[0], ser_data};
      sact_q <= {sact_q[0], ser_active};
      sclk_prev_q <= sclk_q[1];
      bit_cnt_q <= bit_cnt_d;
      shift_q <= shift_d;
      byte_cnt_q <= byte_cnt_d;
      ovf_q <= ovf_d;
      ferr_q <= ferr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_en) mem_q[wr_q] <= shift_nx;
      wr_q <= wr_q + AW'(wr_en);
      rd_q <= rd_q + AW'(pop);
      cnt_q <= cnt_q + (AW+1)'(wr_en) - (AW+1)'(pop);
    end
  end
endmodule

// File: tb/tb_serial_byte_receiver.sv
// tb_serial_byte_receiver: scoreboard bench driving ser_clk at clk/8
module tb_serial_byte_receiver;
  logic clk = 1'b0;
  logic reset, ser_clk, ser_data, ser_active, out_ready;
  logic [7:0] out_data;
  logic out_valid, frame_done, overflow, frame_err;
  logic [7:0] byte_count;
  logic [7:0] exp_q[$];
  logic [7:0] last_pop;
  int n_chk = 0, n_fail = 0, n_pop = 0, lat = 0, p = 0;
  always #5 clk = ~clk;
  serial_byte_receiver dut (
    .clk(clk), .reset(reset), .ser_clk(ser_clk), .ser_data(ser_data),
    .ser_active(ser_active), .out_ready(out_ready), .out_data(out_data),
    .out_valid(out_valid), .byte_count(byte_count), .frame_done(frame_done),
    .overflow(overflow), .frame_err(frame_err)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] model(input logic [7:0] v);
    logic [7:0] r;
`ifdef RX_MSB_FIRST_EN
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
`else
    r = v;
`endif
    return r;
  endfunction
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  // mode 1 measures out_valid latency, mode 2 raises out_ready on the push edge
  task automatic send_bit(input logic b, input int mode);
    ser_data = b;
    tick(4);
    ser_clk = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      if (mode == 1 && out_valid && lat == 0) lat = i;
      if (mode == 2 && i == 2) out_ready = 1'b1;
    end
    ser_clk = 1'b0;
  endtask
  task automatic send_byte(input logic [7:0] v, input int mode, input bit keep);
    if (keep || exp_q.size() < 4) exp_q.push_back(model(v));
    for (int i = 0; i < 8; i++) send_bit(v[i], i == 7 ? mode : 0);
  endtask
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      n_pop++;
      last_pop = out_data;
      check("sb_nonempty", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("out_data", out_data, exp_q.pop_front());
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    reset = 1'b1; ser_clk = 1'b0; ser_data = 1'b0; ser_active = 1'b0; out_ready = 1'b0;
    tick(3);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_count", byte_count, 0);
    check("rst_done", frame_done, 0);
    check("rst_ovf", overflow, 0);
    check("rst_ferr", frame_err, 0);
    reset = 1'b0;
    tick(2);
    out_ready = 1'b1; ser_active = 1'b1; tick(2);
    for (int b = 0; b < 10; b++) send_byte(8'(b), b == 0 ? 1 : 0, 1'b0);
    tick(6);
    check("latency", lat, 3);
    check("f1_count", byte_count, 10);
    check("f1_done", frame_done, 1);
    check("f1_drained", exp_q.size(), 0);
    ser_active = 1'b0; tick(5);
    check("f1_done_clr", frame_done, 0);
    check("f1_count_hold", byte_count, 10);
    out_ready = 1'b0; ser_active = 1'b1; tick(2);
    for (int b = 0; b < 10; b++) send_byte(8'hA5, 0, 1'b0);
    tick(6);
    check("ovf_set", overflow, 1);
    check("ovf_count", byte_count, 10);
    check("ovf_valid", out_valid, 1);
    ser_active = 1'b0; tick(5);
    p = n_pop; out_ready = 1'b1; tick(10);
    check("ovf_pops", n_pop - p, 4);
    check("ovf_empty", out_valid, 0);
    out_ready = 1'b0; ser_active = 1'b1; tick(2);
    for (int b = 0; b < 3; b++) send_byte(8'h21 + 8'(b), 0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
    ser_active = 1'b0; tick(5);
    check("ferr_set", frame_err, 1);
    check("ferr_count", byte_count, 3);
    check("ferr_done", frame_done, 0);
    check("ferr_valid", out_valid, 1);
    p = n_pop; out_ready = 1'b1; tick(8);
    check("ferr_pops", n_pop - p, 3);
    ser_active = 1'b1; tick(5);
    check("restart_ferr", frame_err, 0);
    check("restart_count", byte_count, 0);
    ser_active = 1'b0; tick(5);
    out_ready = 1'b0; ser_active = 1'b1; tick(2);
    send_byte(8'h41, 0, 1'b0);
    send_byte(8'h42, 0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0, 0);
    reset = 1'b1; tick(1);
    check("mrst_valid", out_valid, 0);
    check("mrst_count", byte_count, 0);
    check("mrst_done", frame_done, 0);
    exp_q.delete();
    ser_active = 1'b0; reset = 1'b0; tick(3);
    out_ready = 1'b1; ser_active = 1'b1; tick(2);
    for (int b = 0; b < 10; b++) send_byte(8'h11 + 8'(b), 0, 1'b0);
    tick(6);
    check("f2_done", frame_done, 1);
    check("f2_count", byte_count, 10);
    check("f2_ferr", frame_err, 0);
    check("f2_drained", exp_q.size(), 0);
    ser_active = 1'b0; tick(5);
    out_ready = 1'b0; ser_active = 1'b1; tick(2);
    p = n_pop;
    for (int b = 0; b < 4; b++) send_byte(8'h31 + 8'(b), 0, 1'b0);
    send_byte(8'h35, 2, 1'b1);
    tick(3);
    check("fullpop_ovf", overflow, 0);
    tick(8);
    check("fullpop_pops", n_pop - p, 5);
    check("fullpop_empty", out_valid, 0);
    check("fullpop_drained", exp_q.size(), 0);
    ser_active = 1'b0; tick(5);
    ser_active = 1'b1; tick(2);
    send_byte(8'h01, 0, 1'b0);
    tick(6);
`ifdef RX_MSB_FIRST_EN
    check("bit_order", last_pop, 8'h80);
`else
    check("bit_order", last_pop, 8'h01);
`endif
    check("order_drained", exp_q.size(), 0);
    ser_active = 1'b0; tick(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_byte_receiver.md
Name: serial_byte_receiver

Overview:
- Downstream stage of the SRAM scan/readout block; consumes the serial stream (ser_data sampled on ser_clk rising edges, ser_active as frame enable).
- Deserializes bits LSB-first into bytes, counts bytes per frame, and buffers them in a small FIFO with a valid/ready output for the display or host logic.
- All logic runs on clk; ser_clk is treated as data: synchronized and edge-detected, never used as a clock.

Parameters:
- FRAME_BYTES, 10, bytes per frame; the frame completes when this count is reached.
- FIFO_DEPTH, 4, byte FIFO entries; must be a power of 2, ≥2.
- CNT_W, 8, width of byte_count; must hold FRAME_BYTES.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ser_clk  in  1  serial bit clock from upstream, asynchronous to clk; max frequency clk/4.
- ser_data  in  1  serial data bit, stable around ser_clk rising edge.
- ser_active  in  1  frame enable from upstream; high for the whole frame.
- out_ready  in  1  consumer accepts out_data this cycle.
- out_data  out  8  FIFO head byte.
- out_valid  out  1  FIFO not empty.
- byte_count  out  CNT_W  bytes received in the current frame.
- frame_done  out  1  frame of FRAME_BYTES complete.
- overflow  out  1  sticky: a byte was dropped because the FIFO was full.
- frame_err  out  1  sticky: ser_active fell mid-frame.

Behaviour:
- Reset: reset is synchronous, active-high; clock is clk. Clears all state. FSM=IDLE, FIFO empty, out_valid=0, out_data=0, byte_count=0, frame_done=0, overflow=0, frame_err=0, bit_cnt=0, shift=0.
- Sync: ser_clk, ser_data, and ser_active each pass through 2-flop synchronizers of equal depth. A rise is sclk_s2 & ~sclk_prev. The bit is sampled from the synchronized ser_data on the rise cycle.
- FSM IDLE: waits for synchronized ser_active=1, then goes to SHIFT. On entry it clears bit_cnt, byte_count, overflow, and frame_err. The FIFO is not flushed.
- FSM SHIFT: on each rise, shift[bit_cnt] <= bit and bit_cnt increments (3-bit).
- At bit_cnt==7 with a rise, the assembled byte (including bit 7) is pushed, byte_count increments, and bit_cnt wraps to 0.
- When byte_count reaches FRAME_BYTES, the FSM goes to DONE.
- If synchronized ser_active falls in SHIFT before frame completion: discard the partial byte, set frame_err, go to IDLE. Bytes already pushed stay in the FIFO.
- FSM DONE: frame_done=1. Further rises are ignored. When synchronized ser_active=0, the FSM goes to IDLE and frame_done clears. byte_count holds until the next frame start.
- Latency: out_valid rises 3 clk cycles after the ser_clk rise carrying bit 7, when the FIFO was empty.
- FIFO: out_valid = count!=0; out_data = head entry; pop on out_valid & out_ready.
- Push while full without a simultaneous pop: drop the byte and set overflow. byte_count still increments.
- Push while full with a simultaneous pop: both occur, and count is unchanged.
- Push and pop on an empty FIFO: push only; the new byte is visible the next cycle.
- Pointers wrap modulo FIFO_DEPTH.
- Reset mid-frame: everything returns to reset values on the next clk edge, including the FIFO contents.

Optional Feature:
- RX_MSB_FIRST_EN defined: bits assemble MSB-first. The first bit of a byte lands in shift[7], the last in shift[0].
- RX_MSB_FIRST_EN undefined: LSB-first as above. No other behaviour changes.

Test Plan:
- Send a 10-byte frame with values 0x00..0x09, LSB-first, ser_clk=clk/8, out_ready=1 → out_data sequence 0x00..0x09, byte_count=10, frame_done=1; out_valid rises 3 cycles after bit 7 of byte 0.
- Hold out_ready=0 and send 10 bytes 0xA5 with FIFO_DEPTH=4 → 4 entries of 0xA5 retained, overflow=1, byte_count=10; then out_ready=1 → exactly 4 pops, then out_valid=0.
- Drop ser_active after byte 3, bit 4 → frame_err=1, byte_count=3, FSM IDLE, 3 bytes in FIFO. Restarting ser_active → frame_err=0, byte_count=0.
- Assert reset while in SHIFT mid-byte with 2 bytes buffered → next cycle out_valid=0, byte_count=0, frame_done=0; the following frame 0x11..0x1A is received cleanly.
- With the FIFO full, hold out_ready=1 and push the next byte → the push is accepted, count stays 4, no overflow, and the order is preserved.
- With RX_MSB_FIRST_EN defined, send bit sequence 1,0,0,0,0,0,0,0 → out_data=0x80; undefined → 0x01.
